// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative 32-bit shifter controller that walks the 1/2/4/8/16
// stages of one shared shift datapath, one stage per cycle, skipping stages whose
// count bit is clear and stopping as soon as no higher count bits remain.

package shifterPkg;
  typedef enum logic [2:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    SAR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4,
    RCL = 3'd5,
    RCR = 3'd6
  } shiftOpSel;
endpackage

module shift_sequencer
  import shifterPkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  shiftOpSel   in_op,
  input  logic [4:0]  in_count,
  input  logic [31:0] in_data,
  input  logic        in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_carry,
  output logic        out_zero,
  output logic        out_sign
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned STAGE_W = 3;
  localparam int unsigned SH_W    = 6;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_n;
  shiftOpSel            op_q, op_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic [DATA_W-1:0]    data_q, data_n;
  logic                 carry_q, carry_n;
  logic [STAGE_W-1:0]   stage_q, stage_n;

  logic                 in_ready_q, in_ready_n;
  logic                 out_valid_q, out_valid_n;
  logic [DATA_W-1:0]    out_data_q, out_data_n;
  logic                 out_carry_q, out_carry_n;
  logic                 out_zero_q, out_zero_n;
  logic                 out_sign_q, out_sign_n;

  logic [SH_W-1:0]      sh;
  logic [IDX_W-1:0]     idx_hi;
  logic [IDX_W-1:0]     idx_lo;
  logic [DATA_W:0]      rcx;
  logic [DATA_W:0]      rot;
  logic [DATA_W-1:0]    stage_data;
  logic                 stage_carry;
  logic [CNT_W-1:0]     higher;

  // One shared shift stage: shift {carry,data} by 2^stage for the latched op.
  always_comb begin
    sh          = SH_W'(1) << stage_q;
    idx_hi      = IDX_W'(SH_W'(DATA_W) - sh);
    idx_lo      = IDX_W'(sh - SH_W'(1));
    rcx         = {carry_q, data_q};
    rot         = rcx;
    stage_data  = data_q;
    stage_carry = carry_q;
    case (op_q)
      SHL: begin
        stage_data  = data_q << sh;
        stage_carry = data_q[idx_hi];
      end
      SHR: begin
        stage_data  = data_q >> sh;
        stage_carry = data_q[idx_lo];
      end
      SAR: begin
        stage_data  = DATA_W'($signed(data_q) >>> sh);
        stage_carry = data_q[idx_lo];
      end
      ROL: begin
        stage_data  = (data_q << sh) | (data_q >> (SH_W'(DATA_W) - sh));
        stage_carry = data_q[idx_hi];
      end
      ROR: begin
        stage_data  = (data_q >> sh) | (data_q << (SH_W'(DATA_W) - sh));
        stage_carry = data_q[idx_lo];
      end
      RCL: begin
        rot                       = (rcx << sh) | (rcx >> (SH_W'(DATA_W + 1) - sh));
        {stage_carry, stage_data} = rot;
      end
      RCR: begin
        rot                       = (rcx >> sh) | (rcx << (SH_W'(DATA_W + 1) - sh));
        {stage_carry, stage_data} = rot;
      end
      default: begin
        stage_data  = data_q;
        stage_carry = carry_q;
      end
    endcase
  end

  // Count bits above the current stage; zero means this is the last stage.
  always_comb begin
    higher = count_q >> (stage_q + STAGE_W'(1));
  end

  // Next-state, datapath register and output register logic.
  always_comb begin
    state_n     = state_q;
    op_n        = op_q;
    count_n     = count_q;
    data_n      = data_q;
    carry_n     = carry_q;
    stage_n     = stage_q;
    out_data_n  = out_data_q;
    out_carry_n = out_carry_q;
    out_zero_n  = out_zero_q;
    out_sign_n  = out_sign_q;

    if (flush) begin
      state_n = IDLE;
      stage_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_n    = in_op;
            count_n = in_count;
            data_n  = in_data;
            carry_n = in_carry;
            stage_n = '0;
            if (in_count == '0) begin
              state_n     = DONE;
              out_data_n  = in_data;
              out_carry_n = in_carry;
              out_zero_n  = (in_data == '0);
              out_sign_n  = in_data[DATA_W-1];
            end else begin
              state_n = BUSY;
            end
          end
        end
        BUSY: begin
          if (count_q[stage_q]) begin
            data_n  = stage_data;
            carry_n = stage_carry;
          end
          if (higher == '0) begin
            state_n     = DONE;
            out_data_n  = data_n;
            out_carry_n = carry_n;
            out_zero_n  = (data_n == '0);
            out_sign_n  = data_n[DATA_W-1];
          end else begin
            stage_n = stage_q + STAGE_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          stage_n = '0;
        end
      endcase
    end

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= SHL;
      count_q     <= '0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      stage_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b1;
      out_sign_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      count_q     <= count_n;
      data_q      <= data_n;
      carry_q     <= carry_n;
      stage_q     <= stage_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      out_carry_q <= out_carry_n;
      out_zero_q  <= out_zero_n;
      out_sign_q  <= out_sign_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
  assign out_sign  = out_sign_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.

module tb_shift_sequencer;
  import shifterPkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  shiftOpSel   in_op;
  logic [4:0]  in_count;
  logic [31:0] in_data;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        out_sign;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_count  (in_count),
    .in_data   (in_data),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_sign  (out_sign)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    shiftOpSel   op;
    logic [4:0]  cnt;
    logic [31:0] data;
    logic        cin;
    logic [31:0] exp_data;
    logic        exp_carry;
    int          exp_lat;
  } vec_t;

  // Present one request; returns #1 after the handshake edge (cycle 1).
  task automatic send(input shiftOpSel op, input logic [4:0] cnt,
                      input logic [31:0] data, input logic cin);
    in_op    = op;
    in_count = cnt;
    in_data  = data;
    in_carry = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Find the cycle in which out_valid is first seen; -1 if never within the budget.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Take the result with a one-cycle out_ready pulse.
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    n_checks++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_out_carry got %b want 0", out_carry); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero got %b want 1", out_zero); end
    n_checks++; if (out_sign !== 1'b0) begin n_fail++; $display("FAIL reset_out_sign got %b want 0", out_sign); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    vec_t v[7];
    int lat;
    v[0] = '{SHL, 5'd1,  32'h80000001, 1'b0, 32'h00000002, 1'b1, 2};
    v[1] = '{SAR, 5'd31, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b0, 6};
    v[2] = '{ROL, 5'd8,  32'h12345678, 1'b0, 32'h34567812, 1'b0, 5};
    v[3] = '{RCR, 5'd1,  32'h00000001, 1'b0, 32'h00000000, 1'b1, 2};
    v[4] = '{ROR, 5'd4,  32'h00000001, 1'b0, 32'h10000000, 1'b0, 4};
    v[5] = '{RCL, 5'd31, 32'h00000003, 1'b0, 32'h80000000, 1'b1, 6};
    v[6] = '{SHL, 5'd31, 32'h00000003, 1'b0, 32'h80000000, 1'b1, 6};
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ops[%0d]_in_ready got %b want 1", i, in_ready); end
      send(v[i].op, v[i].cnt, v[i].data, v[i].cin);
      wait_valid(lat);
      n_checks++; if (lat != v[i].exp_lat) begin n_fail++; $display("FAIL ops[%0d]_latency got %0d want %0d", i, lat, v[i].exp_lat); end
      n_checks++; if (out_data !== v[i].exp_data) begin n_fail++; $display("FAIL ops[%0d]_data got %h want %h", i, out_data, v[i].exp_data); end
      n_checks++; if (out_carry !== v[i].exp_carry) begin n_fail++; $display("FAIL ops[%0d]_carry got %b want %b", i, out_carry, v[i].exp_carry); end
      n_checks++; if (out_zero !== (v[i].exp_data == 32'h0)) begin n_fail++; $display("FAIL ops[%0d]_zero got %b want %b", i, out_zero, (v[i].exp_data == 32'h0)); end
      n_checks++; if (out_sign !== v[i].exp_data[31]) begin n_fail++; $display("FAIL ops[%0d]_sign got %b want %b", i, out_sign, v[i].exp_data[31]); end
      consume();
    end
  endtask

  task automatic test_count_zero();
    int lat;
    send(SHR, 5'd0, 32'hDEADBEEF, 1'b1);
    wait_valid(lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL cnt0_latency got %0d want 1", lat); end
    n_checks++; if (out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cnt0_data got %h want deadbeef", out_data); end
    n_checks++; if (out_carry !== 1'b1) begin n_fail++; $display("FAIL cnt0_carry got %b want 1", out_carry); end
    n_checks++; if (out_sign !== 1'b1) begin n_fail++; $display("FAIL cnt0_sign got %b want 1", out_sign); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    send(SHR, 5'd4, 32'h000000F0, 1'b0);
    wait_valid(lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp[%0d]_valid got %b want 1", k, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp[%0d]_in_ready got %b want 0", k, in_ready); end
      n_checks++; if (out_data !== 32'h0000000F) begin n_fail++; $display("FAIL bp[%0d]_data got %h want 0000000f", k, out_data); end
      n_checks++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL bp[%0d]_carry got %b want 0", k, out_carry); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    send(RCL, 5'd1, 32'h80000000, 1'b0);
    wait_valid(lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL b2b_latency got %0d want 2", lat); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL b2b_data got %h want 00000000", out_data); end
    n_checks++; if (out_carry !== 1'b1) begin n_fail++; $display("FAIL b2b_carry got %b want 1", out_carry); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_zero got %b want 1", out_zero); end
    consume();
  endtask

  task automatic test_flush();
    logic seen;
    send(SHR, 5'd20, 32'hFFFF0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_pulse got %b want 0", seen); end
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_count = 5'd0;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_blocks_accept_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    send(SHL, 5'd20, 32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstbusy_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstbusy_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rstbusy_data got %h want 00000000", out_data); end
    n_checks++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL rstbusy_carry got %b want 0", out_carry); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL rstbusy_zero got %b want 1", out_zero); end
    n_checks++; if (out_sign !== 1'b0) begin n_fail++; $display("FAIL rstbusy_sign got %b want 0", out_sign); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = SHL;
    in_count  = 5'd0;
    in_data   = 32'h0;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_count_zero();
    test_reset_mid_busy();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Iterative controller for the execute-stage shifter. It accepts one shift request at a time over a valid/ready handshake and drives a single shared shift-stage datapath through the 1/2/4/8/16 stages on successive cycles, applying only the stages selected by the count bits. It returns the 32-bit result, carry-out and flags to the execute stage. It replaces a fully unrolled five-stage barrel shifter where area matters more than latency, and it terminates early once no higher count bits remain.

## Interface
- No parameters; data width fixed at 32, count width fixed at 5.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight or completed request
- in_valid  in  1  request present
- in_ready  out  1  sequencer can accept a request
- in_op  in  shifterPkg::shiftOpSel  SHL, SHR, SAR, ROL, ROR, RCL, RCR
- in_count  in  5  shift amount, 0..31; no modulo-33 reduction for RCL/RCR
- in_data  in  32  operand
- in_carry  in  1  carry flag in; feeds RCL/RCR and the zero-count result
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_data  out  32  shifted result
- out_carry  out  1  last bit shifted or rotated out
- out_zero  out  1  out_data == 0
- out_sign  out  1  out_data[31]

## Operation
- States: IDLE, BUSY, DONE. Registers: op, count, data, carry, and a 3-bit stage index (0..4).
- IDLE: in_ready=1. When in_valid=1, latch the inputs. If in_count==0, go to DONE with data and carry unchanged. Otherwise go to BUSY with stage=0.
- BUSY: in_ready=0. Each cycle, if count[stage]=1, apply the 2^stage shift for op to {carry,data}. The per-stage carry rule matches the shifter stage semantics:
  - SHL/ROL/RCL: carry takes the bit at position 32-2^stage.
  - SHR/SAR/ROR/RCR: carry takes the bit at position 2^stage-1.
  - RCL/RCR rotate through the 33-bit {carry,data} value.
- If count[stage]=0, data and carry hold for that cycle.
- Exit from BUSY: if count[4:stage+1]==0 (always true at stage 4), go to DONE. Otherwise increment stage.
- DONE: out_valid=1; out_* come straight from registers. Go to IDLE when out_ready=1. Outputs hold stable while out_ready=0.
- Functional result equals a one-shot shift by the full count:
  - SHL carry = data[32-n].
  - SHR/SAR carry = data[n-1].
  - ROL carry = result[0].
  - ROR carry = result[31].
- No overlap: a new request is accepted only in IDLE, so in_ready=1 in the cycle after a DONE handshake at the earliest.
- flush=1 in any state: go to IDLE at the next edge and drop the request. flush has priority over in_valid and out_ready in the same cycle; no request is accepted while flush=1.
- Illegal op value: result and carry are don't-care, but the state sequence is unaffected.

## Timing
- Reset: state=IDLE, stage=0, in_ready=1, out_valid=0, out_data=0, out_carry=0, out_zero=1, out_sign=0.
- Handshake cycle is cycle 0. out_valid rises at cycle 1+B, where B=0 for count 0 and B=msb_index(count)+1 otherwise.
  - count 1 → cycle 2; count 2,3 → 3; count 4..7 → 4; count 8..15 → 5; count 16..31 → 6.
- Throughput: one request per B+2 cycles with out_ready held high.
- Reset or flush asserted mid-BUSY: out_valid stays 0. The next cycle is IDLE with in_ready=1; the aborted result never appears.
- out_* may change only on the DONE entry edge.

## Test plan
- Reset, then SHL data 0x80000001, count 1, carry 0 → out_data 0x00000002, out_carry 1, out_valid at cycle 2, out_zero 0.
- SAR data 0x80000000, count 31 → out_data 0xFFFFFFFF, out_carry 0, out_sign 1, out_valid at cycle 6 (5 BUSY cycles).
- ROL data 0x12345678, count 8 → out_data 0x34567812, out_carry 0, out_valid at cycle 5. Then RCR data 0x00000001, carry 0, count 1 → out_data 0, out_carry 1, out_zero 1.
- Count 0, any op, data 0xDEADBEEF, carry 1 → out_data 0xDEADBEEF, out_carry 1, out_valid at cycle 1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE → outputs stable and in_ready=0 throughout. Release → IDLE next cycle; back-to-back RCL data 0x80000000, carry 0, count 1 → out_data 0, out_carry 1.
- flush at the third BUSY cycle of a count-20 SHR → IDLE next cycle, no out_valid pulse. Same check with reset mid-BUSY → reset values on all outputs.
